nibble_serial_sub: RTL and testbench
====================================

# nibble_serial_sub

Sequential multi-nibble subtractor for the Slipstream datapath. It computes D = A − B − BORROW_IN one 4-bit slice per cycle, with a registered borrow chained between slices, and reports borrow, zero, negative and signed-overflow flags. It complements the combinational 4-bit adder slices: it performs subtraction rather than addition, and it exposes the carry/borrow that those slices do not. Wide operations therefore need only one narrow slice.

## Interface
Parameters:
- WIDTH, default 16: operand width in bits. Must be a multiple of 4 and at least 8.

Ports:
- MasterClock  in  1  system clock; every flop is clocked on its rising edge.
- RESETL  in  1  asynchronous, active-low reset.
- START  in  1  request pulse. Sampled only when BUSY=0.
- A  in  WIDTH  minuend. Sampled with START.
- B  in  WIDTH  subtrahend. Sampled with START.
- BORROW_IN  in  1  initial borrow. Sampled with START.
- BUSY  out  1  high while slices are being processed.
- DONE  out  1  one-cycle pulse marking the cycle in which the new result is first valid.
- D  out  WIDTH  difference. Holds its value between operations.
- BORROW_OUT  out  1  borrow out of the most significant slice, i.e. unsigned A < B + BORROW_IN.
- ZERO  out  1  D == 0.
- NEG  out  1  D[WIDTH-1].
- OVF  out  1  signed overflow: (A[msb] ≠ B[msb]) && (D[msb] ≠ A[msb]).

## Operation
- NIBBLES = WIDTH/4.
- The state machine has three states: IDLE, RUN and FIN.
- IDLE:
  - START=1 latches A, B and BORROW_IN into internal registers.
  - It clears the slice index and the working result, then moves to RUN.
- RUN (BUSY=1):
  - Slice i computes {c, s} = A[4i+3:4i] + ~B[4i+3:4i] + ~borrow.
  - The next borrow is ~c. s is written into working-result nibble i, and the index increments.
  - On the last slice (index NIBBLES−1), the complete difference, the final borrow and the flags are loaded into the output registers, and the machine moves to FIN.
- FIN: DONE=1 and BUSY=0.
  - If START=1, the new operands are latched and the machine moves to RUN (back-to-back operation).
  - Otherwise it returns to IDLE.
- START while BUSY=1 is ignored. No queuing and no error flag.
- The output registers D, BORROW_OUT, ZERO, NEG and OVF change only on the edge entering FIN. They do not change while a later operation is running.
- Changes to A, B or BORROW_IN after the sampling edge have no effect on the current operation.
- Arithmetic is modulo 2^WIDTH. The flag definitions above are exact. NEG and OVF are computed from the latched A and B and the final D.

## Timing
- Reset (RESETL=0, asynchronous): state becomes IDLE and every output is 0, i.e. BUSY=0, DONE=0, D=0, BORROW_OUT=0, ZERO=0, NEG=0, OVF=0. The index, working result and borrow are also cleared.
- Reset asserted mid-operation abandons the operation. The next operation starts cleanly after release.
- Latency: START is sampled at the end of cycle 0.
  - BUSY=1 in cycles 1..NIBBLES.
  - DONE=1 and results valid in cycle NIBBLES+1. For WIDTH=16 that is cycle 5.
- Throughput: one result every NIBBLES+1 cycles when START is held or re-asserted in FIN. Otherwise NIBBLES+2 cycles.
- DONE is never high for two consecutive cycles.
- BUSY and DONE are never high together.

## Structure
- Shared package slipstream_arith_pkg holds:
  - the state enum (IDLE, RUN, FIN);
  - NIBBLE_W = 4;
  - a function computing the overflow flag.
- One sub-module, nibble_addc4: a 4-bit adder with carry-in and carry-out, 9 inputs and 5 outputs, purely combinational.
  - It is instantiated once; the subtraction uses inverted B and inverted borrow.
  - It is the only arithmetic logic in the block.
- The top level contains the FSM, slice index counter, operand registers, borrow flop, working-result register and output registers.

## Test plan
- A=0x1234, B=0x0234, BORROW_IN=0 -> DONE in cycle 5; D=0x1000, BORROW_OUT=0, ZERO=0, NEG=0, OVF=0.
- A=0x0000, B=0x0001 -> D=0xFFFF, BORROW_OUT=1, NEG=1, OVF=0. Also A=0x8000, B=0x0001 -> D=0x7FFF, OVF=1, BORROW_OUT=0.
- A=0x5A5A, B=0x5A5A -> D=0x0000, ZERO=1. Also A=0x0001, B=0x0000, BORROW_IN=1 -> D=0x0000, ZERO=1, BORROW_OUT=0.
- START re-asserted in the FIN cycle with A=0x0010, B=0x0001 -> second DONE exactly 5 cycles after the first, D=0x000F. START pulses in cycles 2–4 of an operation -> ignored; the result matches the first operands only.
- Operands changed every cycle during RUN -> result unaffected. D and the flags hold their previous values until FIN.
- RESETL pulsed low in cycle 3 of an operation -> all outputs 0 immediately, no DONE. A fresh START after release gives the correct result with normal latency.

Source files
------------

// File: rtl/slipstream_arith_pkg.sv
// Shared arithmetic definitions for the Slipstream datapath: serial FSM states,
// slice width and the signed-overflow rule for subtraction.
package slipstream_arith_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } sub_state_e;

  // A - B overflows when the operand signs differ and the result sign leaves A's.
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_addc4.sv
// 4-bit adder slice with carry in/out; the subtractor feeds it ~B and ~borrow.
module nibble_addc4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_sub.sv
// Serial subtractor: D = A - B - BORROW_IN, one nibble per cycle through a
// single adder slice, with flags registered when the last slice completes.
module nibble_serial_sub
  import slipstream_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             MasterClock,
  input  logic             RESETL,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BORROW_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BORROW_OUT,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVF
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  sub_state_e           state;
  logic [IDX_W-1:0]     idx;
  logic [WIDTH-1:0]     a_q, b_q, work_q;
  logic                 borrow_q;
  logic [WIDTH-1:0]     d_q;
  logic                 borrow_out_q, zero_q, neg_q, ovf_q;

  logic [NIBBLE_W-1:0]  a_nib, b_nib, sum_nib;
  logic                 cout;
  logic [WIDTH-1:0]     d_full;

  assign a_nib = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[idx*NIBBLE_W +: NIBBLE_W];

  nibble_addc4 u_slice (
    .a    (a_nib),
    .b    (~b_nib),
    .cin  (~borrow_q),
    .s    (sum_nib),
    .cout (cout)
  );

  // Working result with the current slice merged in; complete on the last slice.
  always_comb begin
    d_full = work_q;
    d_full[idx*NIBBLE_W +: NIBBLE_W] = sum_nib;
  end

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      state        <= IDLE;
      idx          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      work_q       <= '0;
      borrow_q     <= 1'b0;
      d_q          <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      neg_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= BORROW_IN;
            idx      <= '0;
            work_q   <= '0;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          work_q   <= d_full;
          borrow_q <= ~cout;
          idx      <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            d_q          <= d_full;
            borrow_out_q <= ~cout;
            zero_q       <= (d_full == '0);
            neg_q        <= d_full[WIDTH-1];
            ovf_q        <= calc_ovf(a_q[WIDTH-1], b_q[WIDTH-1], d_full[WIDTH-1]);
            idx          <= '0;
            state        <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY       = (state == RUN);
  assign DONE       = (state == FIN);
  assign D          = d_q;
  assign BORROW_OUT = borrow_out_q;
  assign ZERO       = zero_q;
  assign NEG        = neg_q;
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Randomized self-checking bench for nibble_serial_sub against an arithmetic model.
module tb_nibble_serial_sub;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             gclk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             bin;
  logic             busy, done;
  logic [WIDTH-1:0] d;
  logic             bout, zero, neg, ovf;

  int errs   = 0;
  int checks = 0;

  // Expected outputs of the last completed operation (what the registers hold).
  logic [WIDTH-1:0] m_d;
  logic             m_bout, m_zero, m_neg, m_ovf;

  always #5 gclk = ~gclk;

  nibble_serial_sub #(.WIDTH(WIDTH)) dut (
    .MasterClock (gclk),
    .RESETL      (rst_n),
    .START       (start),
    .A           (a),
    .B           (b),
    .BORROW_IN   (bin),
    .BUSY        (busy),
    .DONE        (done),
    .D           (d),
    .BORROW_OUT  (bout),
    .ZERO        (zero),
    .NEG         (neg),
    .OVF         (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_d = '0; m_bout = 0; m_zero = 0; m_neg = 0; m_ovf = 0;
  endtask

  task automatic model_sub(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbin);
    longint diff;
    diff   = longint'(ma) - longint'(mb) - longint'(mbin);
    m_d    = WIDTH'(diff);
    m_bout = (diff < 0);
    m_zero = (m_d == 0);
    m_neg  = m_d[WIDTH-1];
    m_ovf  = (ma[WIDTH-1] != mb[WIDTH-1]) && (m_d[WIDTH-1] != ma[WIDTH-1]);
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".d"},    64'(d),    64'(m_d));
    chk({tag, ".bout"}, 64'(bout), 64'(m_bout));
    chk({tag, ".zero"}, 64'(zero), 64'(m_zero));
    chk({tag, ".neg"},  64'(neg),  64'(m_neg));
    chk({tag, ".ovf"},  64'(ovf),  64'(m_ovf));
  endtask

  // Called at a negedge in IDLE or FIN. Returns at the negedge of the DONE cycle
  // with START low. noise=1 scrambles operands and pulses START while busy.
  task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                       input logic obin, input bit noise, input string tag);
    start = 1; a = oa; b = ob; bin = obin;
    for (int c = 1; c <= NIBBLES; c++) begin
      @(negedge gclk);
      chk({tag, ".busy"}, 64'(busy), 64'd1);
      chk({tag, ".done_lo"}, 64'(done), 64'd0);
      chk_outs({tag, ".hold"});
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
      end
    end
    start = 0;
    @(negedge gclk);
    model_sub(oa, ob, obin);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy_lo"}, 64'(busy), 64'd0);
    chk_outs(tag);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge gclk);
    chk({tag, ".idle_done"}, 64'(done), 64'd0);
    chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
    chk_outs({tag, ".idle"});
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst_n = 0; start = 0; a = '0; b = '0; bin = 0;
    model_clear();
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk_outs("rst");
    @(negedge gclk); @(negedge gclk);
    rst_n = 1;
    idle_cycle("post_rst");

    do_op(16'h1234, 16'h0234, 1'b0, 0, "basic");   idle_cycle("basic");
    do_op(16'h0000, 16'h0001, 1'b0, 0, "wrap");    idle_cycle("wrap");
    do_op(16'h8000, 16'h0001, 1'b0, 0, "ovf");     idle_cycle("ovf");
    do_op(16'h5A5A, 16'h5A5A, 1'b0, 0, "zero");    idle_cycle("zero");
    do_op(16'h0001, 16'h0000, 1'b1, 0, "bin_zero"); idle_cycle("bin_zero");
    do_op(16'h0000, 16'hFFFF, 1'b1, 0, "maxb");    idle_cycle("maxb");

    // Back-to-back: START driven in the FIN cycle; next DONE exactly NIBBLES+1 later.
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 0, "b2b0");
    do_op(16'h0010, 16'h0001, 1'b0, 0, "b2b1");
    idle_cycle("b2b1");

    do_op(16'h4321, 16'h1234, 1'b1, 1, "noise");   idle_cycle("noise");

    // Reset in cycle 3 of an operation abandons it.
    start = 1; a = 16'hABCD; b = 16'h1111; bin = 0;
    @(negedge gclk); start = 0;
    @(negedge gclk);
    @(negedge gclk);
    rst_n = 0;
    #1;
    model_clear();
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk_outs("midrst");
    @(negedge gclk);
    rst_n = 1;
    for (int i = 0; i < NIBBLES + 2; i++) idle_cycle("midrst");
    do_op(16'hABCD, 16'h1111, 1'b0, 0, "after_rst"); idle_cycle("after_rst");

    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = (i % 5 == 0) ? ra : WIDTH'($urandom);
      do_op(ra, rb, 1'($urandom), ($urandom_range(0, 1) == 1), "rnd");
      if ($urandom_range(0, 2) != 0) idle_cycle("rnd");
    end
    idle_cycle("end");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
